// File: rtl/rc4_pkg.sv
// rc4_pkg: shared constants, bus-select encodings and checker state type for the RC4 key search
package rc4_pkg;
    localparam int MSG_LEN = 32;
    localparam logic [7:0] CHAR_A = 8'h61;
    localparam logic [7:0] CHAR_Z = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;
    localparam logic [1:0] S_RAM_SEL = 2'b01;
    localparam logic [1:0] ENC_ROM_SEL = 2'b10;
    localparam logic [1:0] DEC_RAM_SEL = 2'b11;
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, SAMPLE, CHECK, DONE} chk_state_t;
    function automatic logic is_valid_char(input logic [7:0] c);
        return (c >= CHAR_A && c <= CHAR_Z) || c == CHAR_SP;
    endfunction
endpackage

// File: rtl/decrypt_checker.sv
// decrypt_checker: reads back decrypted bytes and flags the first non 'a'..'z'/space character
module decrypt_checker import rc4_pkg::*; #(
    parameter int MSG_LEN = rc4_pkg::MSG_LEN,
    parameter int RD_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] q_data,
    output logic [7:0] address,
    output logic [1:0] memory_sel,
    output logic       check_mem_handler,
    output logic       wen,
    output logic       finish,
    output logic       key_valid,
    output logic [7:0] fail_index
);
    localparam int CW = $clog2(RD_WAIT + 2);
    chk_state_t state;
    logic [8:0] k;
    logic [CW-1:0] cnt;
    logic [7:0] byte_r;
    assign wen = 1'b0;
    // bus ownership and address are updated on entry to ADDR so they are valid throughout ADDR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k <= '0;
            cnt <= '0;
            byte_r <= '0;
            address <= '0;
            memory_sel <= '0;
            check_mem_handler <= 1'b0;
            finish <= 1'b0;
            key_valid <= 1'b0;
            fail_index <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    k <= '0;
                    key_valid <= 1'b0;
                    fail_index <= '0;
                    address <= '0;
                    check_mem_handler <= 1'b1;
                    memory_sel <= DEC_RAM_SEL;
                    state <= ADDR;
                end
                ADDR: begin
                    cnt <= CW'(RD_WAIT);
                    state <= (RD_WAIT == 0) ? SAMPLE : WAIT;
                end
                WAIT: if (cnt == '0) state <= SAMPLE; else cnt <= cnt - 1'b1;
                SAMPLE: begin
                    byte_r <= q_data;
                    state <= CHECK;
                end
                CHECK: if (!is_valid_char(byte_r) || k == 9'(MSG_LEN - 1)) begin
                    key_valid <= is_valid_char(byte_r);
                    fail_index <= is_valid_char(byte_r) ? 8'd0 : k[7:0];
                    finish <= 1'b1;
                    check_mem_handler <= 1'b0;
                    memory_sel <= '0;
                    state <= DONE;
                end else begin
                    k <= k + 9'd1;
                    address <= k[7:0] + 8'd1;
                    state <= ADDR;
                end
                DONE: if (!start) begin
                    finish <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decrypt_checker.sv
// tb_decrypt_checker: randomized and directed checks of decrypt_checker against a scan-based model
module tb_decrypt_checker;
    import rc4_pkg::*;
    localparam int W1 = 1;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0;
    logic [7:0] ram1 [32];
    logic [7:0] ram2 [256];
    logic [7:0] addr1, addr2, fi1, fi2, q1, q2;
    logic [1:0] sel1, sel2;
    logic h1, h2, wen1, wen2, fin1, fin2, kv1, kv2;
    int passed = 0, total = 0;
    int exp_kv = 0, exp_fi = 0, exp_stop = 0, mx1 = 0, last_cyc = 0;
    logic fq1 = 1'b0;

    assign q1 = ram1[addr1[4:0]];
    assign q2 = ram2[addr2];
    always #5 clk = ~clk;

    decrypt_checker #(.MSG_LEN(32), .RD_WAIT(W1)) dut (
        .clk(clk), .reset(reset), .start(start), .q_data(q1), .address(addr1),
        .memory_sel(sel1), .check_mem_handler(h1), .wen(wen1), .finish(fin1),
        .key_valid(kv1), .fail_index(fi1));

    decrypt_checker #(.MSG_LEN(256), .RD_WAIT(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .q_data(q2), .address(addr2),
        .memory_sel(sel2), .check_mem_handler(h2), .wen(wen2), .finish(fin2),
        .key_valid(kv2), .fail_index(fi2));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic bit ok(input logic [7:0] b);
        return b == 8'h20 || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    task automatic model1();
        exp_kv = 1; exp_fi = 0; exp_stop = 31;
        for (int i = 31; i >= 0; i--)
            if (!ok(ram1[i])) begin exp_kv = 0; exp_fi = i; exp_stop = i; end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("wen", int'(wen1), 0);
            chk("sel_vs_own", int'(sel1), h1 ? int'(DEC_RAM_SEL) : 0);
            if (h1 && int'(addr1) > mx1) mx1 = int'(addr1);
            if (fin1 && !fq1) chk("max_addr", mx1, exp_stop);
            if (fin1) begin
                chk("key_valid", int'(kv1), exp_kv);
                chk("fail_index", int'(fi1), exp_fi);
                chk("own_in_done", int'(h1), 0);
            end
        end
        fq1 = fin1;
    end

    task automatic run1(input int hold);
        int cyc;
        logic [7:0] a;
        model1();
        mx1 = 0;
        @(negedge clk);
        start = 1'b1;
        cyc = 1;
        while (!fin1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) chk("first_addr", int'(addr1), 0);
        end
        last_cyc = cyc;
        chk("finish_seen", int'(fin1), 1);
        chk("latency", cyc, (exp_stop + 1) * (4 + W1) + 2);
        a = addr1;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_addr", int'(addr1), int'(a));
            chk("hold_finish", int'(fin1), 1);
        end
        start = 1'b0;
        @(negedge clk);
        chk("finish_drop", int'(fin1), 0);
        chk("result_kept", int'(kv1), exp_kv);
        chk("index_kept", int'(fi1), exp_fi);
    endtask

    task automatic run2(input int e_kv, input int e_fi);
        int cyc, mx2, prev, wrap;
        mx2 = 0; prev = 0; wrap = 0;
        @(negedge clk);
        start2 = 1'b1;
        cyc = 1;
        while (!fin2 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (h2) begin
                if (int'(addr2) < prev) wrap = 1;
                prev = int'(addr2);
                if (int'(addr2) > mx2) mx2 = int'(addr2);
            end
        end
        chk("m256_finish", int'(fin2), 1);
        chk("m256_kv", int'(kv2), e_kv);
        chk("m256_fi", int'(fi2), e_fi);
        chk("m256_max_addr", mx2, e_kv ? 255 : e_fi);
        chk("m256_no_wrap", wrap, 0);
        repeat (3) @(negedge clk);
        chk("m256_addr_hold", int'(addr2), e_kv ? 255 : e_fi);
        chk("m256_sel_done", int'(sel2), 0);
        chk("m256_wen", int'(wen2), 0);
        start2 = 1'b0;
        @(negedge clk);
        chk("m256_finish_drop", int'(fin2), 0);
    endtask

    task automatic fill_valid();
        int v;
        for (int i = 0; i < 32; i++) begin
            v = $urandom_range(0, 26);
            ram1[i] = (v == 26) ? 8'h20 : 8'h61 + 8'(v);
        end
    endtask

    initial begin
        string s;
        logic [7:0] bad [6];
        logic [7:0] b;
        int c;
        bad[0] = 8'h60; bad[1] = 8'h7B; bad[2] = 8'h00;
        bad[3] = 8'hFF; bad[4] = 8'h1F; bad[5] = 8'h21;
        s = "the quick brown fox jumps over t";
        for (int i = 0; i < 32; i++) ram1[i] = s[i];
        for (int i = 0; i < 256; i++) ram2[i] = 8'h20;
        repeat (2) @(negedge clk);
        chk("rst_addr", int'(addr1), 0);
        chk("rst_sel", int'(sel1), 0);
        chk("rst_own", int'(h1), 0);
        chk("rst_finish", int'(fin1), 0);
        chk("rst_kv", int'(kv1), 0);
        chk("rst_fi", int'(fi1), 0);
        reset = 1'b0;
        @(negedge clk);

        run1(3);
        chk("t1_latency", last_cyc, 162);
        chk("t1_kv", int'(kv1), 1);

        ram1[5] = 8'h41;
        run1(2);
        chk("t2_fi", int'(fi1), 5);
        chk("t2_max_addr", mx1, 5);
        chk("t2_latency", last_cyc, 32);

        fill_valid();
        ram1[1] = 8'h20; ram1[2] = 8'h61; ram1[3] = 8'h7A;
        run1(0);
        chk("t3_edges_pass", int'(kv1), 1);
        for (int j = 0; j < 3; j++) begin
            ram1[0] = (j == 0) ? 8'h60 : (j == 1) ? 8'h7B : 8'h1F;
            run1(1);
            chk("t3_fi0", int'(fi1), 0);
            chk("t3_kv0", int'(kv1), 0);
        end

        fill_valid();
        model1();
        mx1 = 0;
        @(negedge clk);
        start = 1'b1;
        c = 0;
        while (addr1 != 8'd10 && c < 500) begin @(negedge clk); c++; end
        chk("t5_reached_k10", int'(addr1), 10);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_addr", int'(addr1), 0);
        chk("t5_sel", int'(sel1), 0);
        chk("t5_own", int'(h1), 0);
        chk("t5_finish", int'(fin1), 0);
        chk("t5_kv", int'(kv1), 0);
        chk("t5_fi", int'(fi1), 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run1(1);

        for (int r = 0; r < 25; r++) begin
            fill_valid();
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 1) b = bad[$urandom_range(0, 5)];
                else begin
                    b = 8'($urandom_range(0, 255));
                    while (ok(b)) b = 8'($urandom_range(0, 255));
                end
                ram1[$urandom_range(0, 31)] = b;
            end
            run1($urandom_range(0, 4));
        end

        run2(1, 0);
        ram2[200] = 8'h7B;
        run2(0, 200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
